// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Opcode/funct constants, FSM states and datapath control codes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU,
    C_SUBU,
    C_ORI,
    C_LUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_JAL,
    C_ILL
  } iclass_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_HIGH  = 2'b10;
  localparam logic [1:0] EXT_SHL2  = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b011;

  localparam logic [1:0] NPC_PC4   = 2'b00;
  localparam logic [1:0] NPC_BR    = 2'b01;
  localparam logic [1:0] NPC_JMP   = 2'b10;

  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MEM   = 2'b01;
  localparam logic [1:0] M2R_PC4   = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier for the MIPS controller.
// Anything outside the supported set maps to C_ILL.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  always_comb begin
    iclass = C_ILL;
    case (opcode)
      OP_R: begin
        if (funct == FN_ADDU)
          iclass = C_ADDU;
        else if (funct == FN_SUBU)
          iclass = C_SUBU;
        else
          iclass = C_ILL;
      end
      OP_ORI:  iclass = C_ORI;
      OP_LUI:  iclass = C_LUI;
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_ILL;
    endcase
  end

  assign illegal = (iclass == C_ILL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXE/MEM/WB FSM.
// Optional retired-instruction counter under `PERF_CNT_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic [1:0]       ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       npc_op,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic             mem_wr,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t  state_q;
  state_t  state_d;
  iclass_t cls;
  logic    dec_ill;

  ctrl_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .iclass  (cls),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    ext_op     = EXT_SIGN;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    npc_op     = NPC_PC4;
    reg_wr     = 1'b0;
    reg_dst    = DST_RT;
    mem_wr     = 1'b0;
    mem_to_reg = M2R_ALU;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_ill) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else if (cls == C_J || cls == C_JAL) begin
          pc_wr   = 1'b1;
          npc_op  = NPC_JMP;
          state_d = S_FETCH;
          if (cls == C_JAL) begin
            reg_wr     = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = M2R_PC4;
          end
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        state_d = S_WB;
        case (cls)
          C_ADDU, C_SUBU: alu_op = ALU_FUNCT;
          C_ORI: begin
            ext_op  = EXT_ZERO;
            alu_src = 1'b1;
            alu_op  = ALU_OR;
          end
          // lui relies on rs=$0, so OR passes the shifted immediate
          C_LUI: begin
            ext_op  = EXT_HIGH;
            alu_src = 1'b1;
            alu_op  = ALU_OR;
          end
          C_LW, C_SW: begin
            ext_op  = EXT_SIGN;
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            state_d = S_MEM;
          end
          C_BEQ: begin
            ext_op  = EXT_SHL2;
            alu_op  = ALU_SUB;
            npc_op  = NPC_BR;
            pc_wr   = zero;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          if (cls == C_SW) begin
            mem_wr  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
        if (cls == C_ADDU || cls == C_SUBU)
          reg_dst = DST_RD;
        else if (cls == C_LW)
          mem_to_reg = M2R_MEM;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      mem_req    = 1'b0;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      ext_op     = 2'b00;
      alu_src    = 1'b0;
      alu_op     = 3'b000;
      npc_op     = 2'b00;
      reg_wr     = 1'b0;
      reg_dst    = 2'b00;
      mem_wr     = 1'b0;
      mem_to_reg = 2'b00;
      illegal    = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  // Legal instruction completing: any non-FETCH state heading back to FETCH
  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH) && !dec_ill;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (retire)
      cnt_q <= cnt_q + 1'b1;
  end

  assign instr_cnt = reset ? '0 : cnt_q;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl (CNT_W=4).
// Each entry carries per-cycle stimulus plus the expected control vector.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, pc_wr, ir_wr, alu_src;
  logic       reg_wr, mem_wr, illegal;
  logic [1:0] ext_op, npc_op, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [3:0] instr_cnt;
  logic [17:0] obs;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .pc_wr      (pc_wr),
    .ir_wr      (ir_wr),
    .ext_op     (ext_op),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .npc_op     (npc_op),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .mem_wr     (mem_wr),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .instr_cnt  (instr_cnt)
  );

  assign obs = {mem_req, pc_wr, ir_wr, ext_op, alu_src, alu_op,
                npc_op, reg_wr, reg_dst, mem_wr, mem_to_reg, illegal};

  typedef struct {
    logic        rst;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [17:0] exp;
    logic [3:0]  cnt;
  } ent_t;

  ent_t sb[$];
  ent_t e;
  int   nvec = 0;
  int   nerr = 0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_fn = 6'd0;
  logic [3:0] mcnt = 4'd0;

  function automatic logic [17:0] mk(
    input logic mq, pw, iw, input logic [1:0] ex, input logic as,
    input logic [2:0] ao, input logic [1:0] np, input logic rw,
    input logic [1:0] rd, input logic mw, input logic [1:0] m2,
    input logic il);
    return {mq, pw, iw, ex, as, ao, np, rw, rd, mw, m2, il};
  endfunction

  logic [17:0] v_f1, v_fw, v_nil, v_er, v_wr, v_ema, v_mw;
  logic [17:0] v_wlw, v_msw, v_eori, v_elui, v_wi;
  logic [17:0] v_beq1, v_beq0, v_j, v_jal, v_ill;

  initial begin
    v_f1   = mk(1,1,1,0,0,0,0,0,0,0,0,0);
    v_fw   = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    v_nil  = mk(0,0,0,0,0,0,0,0,0,0,0,0);
    v_er   = mk(0,0,0,0,0,3,0,0,0,0,0,0);
    v_wr   = mk(0,0,0,0,0,0,0,1,1,0,0,0);
    v_ema  = mk(0,0,0,0,1,0,0,0,0,0,0,0);
    v_mw   = mk(1,0,0,0,0,0,0,0,0,0,0,0);
    v_wlw  = mk(0,0,0,0,0,0,0,1,0,0,1,0);
    v_msw  = mk(1,0,0,0,0,0,0,0,0,1,0,0);
    v_eori = mk(0,0,0,1,1,2,0,0,0,0,0,0);
    v_elui = mk(0,0,0,2,1,2,0,0,0,0,0,0);
    v_wi   = mk(0,0,0,0,0,0,0,1,0,0,0,0);
    v_beq1 = mk(0,1,0,3,0,1,1,0,0,0,0,0);
    v_beq0 = mk(0,0,0,3,0,1,1,0,0,0,0,0);
    v_j    = mk(0,1,0,0,0,0,2,0,0,0,0,0);
    v_jal  = mk(0,1,0,0,0,0,2,1,2,0,2,0);
    v_ill  = mk(0,0,0,0,0,0,0,0,0,0,0,1);
  end

  task automatic push(input logic rst, mr, z, input logic [17:0] x);
    ent_t n;
    n.rst = rst; n.mr = mr; n.z = z;
    n.op = cur_op; n.fn = cur_fn;
    n.exp = x;
    n.cnt = rst ? 4'd0 : mcnt;
    sb.push_back(n);
    if (rst) mcnt = 4'd0;
  endtask

  task automatic retire();
`ifdef PERF_CNT_EN
    mcnt = mcnt + 4'd1;
`endif
  endtask

  task automatic set_instr(input logic [5:0] op, fn);
    cur_op = op;
    cur_fn = fn;
  endtask

  task automatic test_reset();
    push(1, 1, 0, v_nil);
    push(1, 1, 0, v_nil);
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL reset obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_addu();
    set_instr(6'b000000, 6'b100001);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_nil);
    push(0, 1, 0, v_er);
    push(0, 1, 0, v_wr);
    retire();
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL addu obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_lw_wait();
    set_instr(6'b100011, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 0, 0, v_nil);
    push(0, 1, 0, v_ema);
    push(0, 0, 0, v_mw);
    push(0, 0, 0, v_mw);
    push(0, 1, 0, v_mw);
    push(0, 1, 0, v_wlw);
    retire();
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL lw_wait obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_beq();
    set_instr(6'b000100, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 1, v_nil);
    push(0, 1, 1, v_beq1);
    retire();
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_nil);
    push(0, 1, 0, v_beq0);
    retire();
    push(0, 0, 1, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL beq obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_jump_illegal();
    set_instr(6'b000011, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_jal);
    retire();
    set_instr(6'b000010, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_j);
    retire();
    set_instr(6'b111111, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_ill);
    set_instr(6'b000000, 6'b000000);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_ill);
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL jump_illegal obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_sw_reset();
    set_instr(6'b101011, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_nil);
    push(0, 1, 0, v_ema);
    push(0, 0, 0, v_mw);
    push(1, 1, 0, v_nil);
    push(0, 0, 0, v_fw);
    set_instr(6'b101011, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_nil);
    push(0, 1, 0, v_ema);
    push(0, 1, 0, v_msw);
    retire();
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL sw_reset obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_instr(6'b000000, 6'b100011);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_nil);
    push(0, 1, 0, v_er);
    push(0, 1, 0, v_wr);
    retire();
    set_instr(6'b001111, 6'd0);
    push(0, 1, 0, v_f1);
    push(0, 1, 0, v_nil);
    push(0, 1, 0, v_elui);
    push(0, 1, 0, v_wi);
    retire();
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL back_to_back obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  task automatic test_count_wrap();
    push(1, 0, 0, v_nil);
    set_instr(6'b001101, 6'd0);
    for (int i = 0; i < 17; i++) begin
      push(0, 1, 0, v_f1);
      push(0, 1, 0, v_nil);
      push(0, 1, 0, v_eori);
      push(0, 1, 0, v_wi);
      retire();
    end
    push(0, 0, 0, v_fw);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; mem_ready = e.mr; zero = e.z;
      opcode = e.op; funct = e.fn;
      #1;
      nvec++;
      if (obs !== e.exp || instr_cnt !== e.cnt) begin
        nerr++;
        $display("FAIL count_wrap obs=%h exp=%h cnt=%0d exp_cnt=%0d",
                 obs, e.exp, instr_cnt, e.cnt);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jump_illegal();
    test_sw_reset();
    test_back_to_back();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
